// File: rtl/fifo_to_mem_writer_pkg.sv
// Shared types and helpers for the stream-to-memory writer.
// Latency: none (types only); backpressure: n/a.
package fifo_to_mem_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_to_mem_writer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; rdata shows the head word combinationally.
// Latency: push visible to pop next cycle; backpressure: full refuses push, empty refuses pop.
module sync_fifo
    import fifo_to_mem_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [clog2(FIFO_DEPTH):0]    count
);

    localparam int PW = clog2(FIFO_DEPTH);
    localparam logic [PW:0] ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DATA_WIDTH-1:0] storage [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (PW + 1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_to_mem_writer.sv
// Buffers a word stream and, on start, writes xfer_len words to consecutive RAM addresses.
// Latency: 1 cycle pop-to-write; backpressure: in_ready low when FIFO full, writes stall when empty.
module fifo_to_mem_writer
    import fifo_to_mem_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 10
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_ready,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH:0]           xfer_len,
    output logic                          busy,
    output logic                          done,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [clog2(FIFO_DEPTH):0]    fifo_count
);

    localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base;
    logic [ADDR_WIDTH:0]     len;
    logic [ADDR_WIDTH:0]     idx;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_rdata;
    logic                    push;
    logic                    pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == RUN) && !fifo_empty && (idx < len);

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= pop;
            done   <= 1'b0;

            // Address uses the pre-increment index; the sum wraps at 2^ADDR_WIDTH.
            if (pop) begin
                mem_addr  <= base + idx[ADDR_WIDTH-1:0];
                mem_wdata <= fifo_rdata;
                idx       <= idx + IDX_ONE;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (xfer_len != '0) begin
                            base  <= base_addr;
                            len   <= xfer_len;
                            idx   <= '0;
                            state <= RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (pop && ((idx + IDX_ONE) == len)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
